// File: rtl/item_responder_pkg.sv
// Shared types and default sizing for the item_responder target.
// The op encoding matches the two-bit req_op field on the request channel.
package item_responder_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_XOR  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    // Response layout at the default data width; err is the ADD carry-out.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  err;
    } rsp_t;

    function automatic logic is_read(input op_e op);
        return op == OP_READ;
    endfunction

endpackage

// File: rtl/item_responder_if.sv
// Request/response bus between an item-level initiator and item_responder.
// master drives requests and consumes responses; slave is the target side.
interface item_responder_if
    import item_responder_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [CNT_W-1:0]  count;

    modport master (
        output req_valid, req_op, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, count
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, count
    );

endinterface

// File: rtl/item_responder_resp_fifo.sv
// In-order response FIFO with occupancy count; head reads as zero when empty.
// Push while full and pop while empty are ignored, so count stays in 0..DEPTH.
module item_responder_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = logic [7:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  entry_t                   wdata_i,
    input  logic                     pop_i,
    output entry_t                   rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? entry_t'('0) : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/item_responder.sv
// Item-level request/response target: accumulator with LOAD/ADD/XOR/READ ops,
// one queued response per accepted request, drained in order.
module item_responder
    import item_responder_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    item_responder_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } entry_t;

    op_e               op;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W:0]   sum;
    entry_t            push_entry;
    entry_t            head;
    logic              push;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    assign op   = op_e'(bus.req_op);
    assign sum  = {1'b0, acc_q} + {1'b0, bus.req_data};
    assign push = bus.req_valid && bus.req_ready;

    always_comb begin
        acc_d      = acc_q;
        push_entry = '0;
        unique case (op)
            OP_LOAD: begin
                acc_d           = bus.req_data;
                push_entry.data = bus.req_data;
            end
            OP_ADD: begin
                acc_d           = sum[DATA_W-1:0];
                push_entry.data = sum[DATA_W-1:0];
                push_entry.err  = sum[DATA_W];
            end
            OP_XOR: begin
                acc_d           = acc_q ^ bus.req_data;
                push_entry.data = acc_q ^ bus.req_data;
            end
            OP_READ: begin
                push_entry.data = acc_q;
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (push && !is_read(op)) begin
            acc_q <= acc_d;
        end
    end

    item_responder_resp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_resp_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (bus.rsp_ready),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Ready looks only at the registered count, never at a same-cycle pop.
    assign bus.req_ready = !full;
    assign bus.rsp_valid = !empty;
    assign bus.rsp_data  = head.data;
    assign bus.rsp_err   = head.err;
    assign bus.count     = count;

endmodule

// File: tb/tb_item_responder.sv
// Scenario bench for item_responder: directed cases from the test plan plus a
// randomized run against a queue-based behavioural model.
module tb_item_responder;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int          MOD    = 1 << DATA_W;

    logic clk = 1'b0;
    logic rst;

    item_responder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    item_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: accumulator value and queue of {data, err} responses.
    int              acc_m;
    logic [DATA_W:0] exp_q [$];

    task automatic model_push(input logic [1:0] op, input int d);
        int s;
        logic [DATA_W:0] r;
        case (op)
            2'd0: begin
                acc_m = d;
                r = {DATA_W'(d), 1'b0};
            end
            2'd1: begin
                s = acc_m + d;
                acc_m = s % MOD;
                r = {DATA_W'(acc_m), 1'(s >= MOD)};
            end
            2'd2: begin
                acc_m = acc_m ^ d;
                r = {DATA_W'(acc_m), 1'b0};
            end
            default: r = {DATA_W'(acc_m), 1'b0};
        endcase
        exp_q.push_back(r);
    endtask

    function automatic logic [DATA_W:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : '0;
    endfunction

    // Advance one clock, updating the model from what the bench is driving.
    task automatic tick();
        bit do_push, do_pop;
        if (rst) begin
            acc_m = 0;
            exp_q.delete();
        end else begin
            do_push = bus.req_valid && (exp_q.size() < DEPTH);
            do_pop  = bus.rsp_ready && (exp_q.size() > 0);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) model_push(bus.req_op, int'(bus.req_data));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [DATA_W-1:0] d);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = d;
        tick();
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd0;
        bus.req_data  = 8'hAA;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++;
            $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.count !== CNT_W'(0)) begin errors++;
            $display("FAIL reset_count: got %0d want 0", bus.count); end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00) begin errors++;
            $display("FAIL reset_no_rsp: got valid %b data %h want 0/00",
                     bus.rsp_valid, bus.rsp_data); end
    endtask

    task automatic test_ops();
        logic [1:0]        ops  [4];
        logic [DATA_W-1:0] din  [4];
        logic [DATA_W-1:0] wd   [4];
        ops = '{2'd0, 2'd1, 2'd2, 2'd3};
        din = '{8'h10, 8'h05, 8'hFF, 8'h00};
        wd  = '{8'h10, 8'h15, 8'hEA, 8'hEA};
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(ops[i], din[i]);
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++;
                $display("FAIL ops_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
            checks++; if (bus.rsp_data !== wd[i] || bus.rsp_err !== 1'b0) begin errors++;
                $display("FAIL ops_rsp[%0d]: got %h/%b want %h/0", i, bus.rsp_data,
                         bus.rsp_err, wd[i]); end
            checks++; if (bus.count !== CNT_W'(1) || bus.req_ready !== 1'b1) begin errors++;
                $display("FAIL ops_b2b[%0d]: got count %0d ready %b want 1/1", i,
                         bus.count, bus.req_ready); end
        end
        bus.req_valid = 1'b0;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.count !== CNT_W'(0)) begin errors++;
            $display("FAIL ops_drained: got valid %b count %0d want 0/0",
                     bus.rsp_valid, bus.count); end
    endtask

    task automatic test_overflow();
        bus.rsp_ready = 1'b1;
        send(2'd0, 8'hF0);
        send(2'd1, 8'h20);
        checks++; if (bus.rsp_data !== 8'h10 || bus.rsp_err !== 1'b1) begin errors++;
            $display("FAIL add_carry: got %h/%b want 10/1", bus.rsp_data, bus.rsp_err); end
        send(2'd3, 8'h5A);
        checks++; if (bus.rsp_data !== 8'h10 || bus.rsp_err !== 1'b0) begin errors++;
            $display("FAIL read_after_carry: got %h/%b want 10/0",
                     bus.rsp_data, bus.rsp_err); end
        bus.req_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] got [$];
        bit accepted;
        do_reset();
        bus.rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(2'd0, DATA_W'(i));
            checks++; if (bus.count !== CNT_W'(i)) begin errors++;
                $display("FAIL bp_fill[%0d]: got count %0d want %0d", i, bus.count, i); end
        end
        bus.req_op   = 2'd0;
        bus.req_data = 8'd5;
        checks++; if (bus.req_ready !== 1'b0) begin errors++;
            $display("FAIL bp_full_ready: got %b want 0", bus.req_ready); end
        tick();
        tick();
        checks++; if (bus.count !== CNT_W'(DEPTH) || bus.rsp_data !== 8'd1) begin errors++;
            $display("FAIL bp_held: got count %0d head %h want 4/01", bus.count,
                     bus.rsp_data); end
        bus.rsp_ready = 1'b1;
        accepted = 1'b0;
        for (int c = 0; c < 20 && got.size() < 5; c++) begin
            if (bus.rsp_valid) got.push_back(bus.rsp_data);
            if (bus.req_valid && bus.req_ready) accepted = 1'b1;
            tick();
            if (accepted) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL bp_drain_timeout: got %0d responses want 5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++; if (got[k] !== DATA_W'(k + 1)) begin errors++;
                    $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], k + 1); end
            end
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd0, DATA_W'(8'h30 + i));
        bus.req_op   = 2'd0;
        bus.req_data = 8'h77;
        checks++; if (bus.count !== CNT_W'(DEPTH) || bus.req_ready !== 1'b0) begin errors++;
            $display("FAIL fp_full: got count %0d ready %b want 4/0", bus.count,
                     bus.req_ready); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++; if (bus.count !== CNT_W'(3) || bus.req_ready !== 1'b1) begin errors++;
            $display("FAIL fp_after_pop: got count %0d ready %b want 3/1", bus.count,
                     bus.req_ready); end
        checks++; if (bus.rsp_data !== 8'h31) begin errors++;
            $display("FAIL fp_head: got %h want 31", bus.rsp_data); end
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.count !== CNT_W'(DEPTH) || bus.req_ready !== 1'b0) begin errors++;
            $display("FAIL fp_refill: got count %0d ready %b want 4/0", bus.count,
                     bus.req_ready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.rsp_ready = 1'b0;
        send(2'd0, 8'h11);
        send(2'd1, 8'h44);
        send(2'd3, 8'h00);
        bus.req_valid = 1'b0;
        checks++; if (bus.count !== CNT_W'(3)) begin errors++;
            $display("FAIL rm_count3: got %0d want 3", bus.count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.count !== CNT_W'(0) || bus.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rm_cleared: got count %0d valid %b want 0/0", bus.count,
                     bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 8'h00 || bus.req_ready !== 1'b1) begin errors++;
            $display("FAIL rm_outputs: got data %h ready %b want 00/1", bus.rsp_data,
                     bus.req_ready); end
        bus.rsp_ready = 1'b1;
        send(2'd3, 8'hFF);
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h00 ||
                      bus.rsp_err !== 1'b0) begin errors++;
            $display("FAIL rm_read_zero: got %b %h/%b want 1 00/0", bus.rsp_valid,
                     bus.rsp_data, bus.rsp_err); end
        tick();
    endtask

    task automatic test_random();
        bit hold;
        do_reset();
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!hold) begin
                bus.req_valid = ($urandom_range(0, 3) != 0);
                bus.req_op    = 2'($urandom);
                bus.req_data  = DATA_W'($urandom);
            end
            bus.rsp_ready = ($urandom_range(0, 99) < ((i < 200) ? 30 : 75));
            checks++; if (bus.count !== CNT_W'(exp_q.size())) begin errors++;
                $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.count,
                         exp_q.size()); end
            checks++; if (bus.req_ready !== (exp_q.size() < DEPTH) ||
                          bus.rsp_valid !== (exp_q.size() > 0)) begin errors++;
                $display("FAIL rnd_flags[%0d]: got ready %b valid %b want %b %b", i,
                         bus.req_ready, bus.rsp_valid, exp_q.size() < DEPTH,
                         exp_q.size() > 0); end
            checks++; if ({bus.rsp_data, bus.rsp_err} !== exp_head()) begin errors++;
                $display("FAIL rnd_head[%0d]: got %h/%b want %h", i, bus.rsp_data,
                         bus.rsp_err, exp_head()); end
            hold = bus.req_valid && !bus.req_ready && !rst;
            tick();
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'd0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        acc_m = 0;
        test_reset();
        test_ops();
        test_overflow();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/item_responder.md
# item_responder

Synchronous request/response target that sits at the far end of the item-level valid/ready interface the general driver initiates. It accepts one operation per handshake, updates an internal accumulator, and queues exactly one response per accepted request. Responses go into a small in-order response FIFO that the monitor side drains with its own valid/ready handshake. It is the reference DUT the general agent/scoreboard environment is exercised against.

## Interface
- DATA_W, 8: width of request data, accumulator and response data.
- DEPTH, 4: response FIFO depth; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count; derived, not overridden.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  target can accept a request.
- req_op  in  2  operation: 00 LOAD, 01 ADD, 10 XOR, 11 READ.
- req_data  in  DATA_W  operand; ignored for READ.
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DATA_W  response value.
- rsp_err  out  1  response flag; carry-out for ADD, else 0.
- count  out  CNT_W  responses currently queued, 0..DEPTH.

## Operation
- Request accepted on a cycle where req_valid && req_ready. Sampled on that edge.
- req_ready = (count != DEPTH). It is combinational from registered count only. It does not depend on the same-cycle pop.
- Per accepted op, with acc being the accumulator:
  - LOAD: acc ← data. Response is {data, 0}.
  - ADD: {carry, acc} ← acc + data. Response is {new acc, carry}. The sum is modulo 2^DATA_W.
  - XOR: acc ← acc ^ data. Response is {new acc, 0}.
  - READ: acc unchanged. Response is {acc, 0}.
- Each accepted request pushes exactly one response. Responses are strictly in request order.
- Pop on rsp_valid && rsp_ready. rsp_valid = (count != 0).
- rsp_data and rsp_err always present the head entry. They hold their value while rsp_valid && !rsp_ready.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full:
  - req_ready = 0, so no push can occur.
  - A pop in the full cycle raises req_ready on the next cycle.
- Empty: rsp_valid = 0. rsp_data and rsp_err then show 0 (mux to zero when empty).
- Pointers wrap modulo DEPTH. count never exceeds DEPTH or goes below 0.
- req_valid with req_ready low: no state change. The initiator must hold the request stable.
- Reset (any time, including mid-burst):
  - acc = 0, count = 0, pointers = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0, req_ready = 1.
  - Queued responses are discarded.
  - A request presented in the reset cycle is not accepted.

## Timing
- Request-to-response latency is 1 cycle when the FIFO is empty. A response for a request accepted at edge N is visible (rsp_valid = 1) after edge N.
- Back-to-back throughput is 1 request/cycle while rsp_ready = 1: steady state count = 1, req_ready stays high.
- The accumulator update is visible to the next accepted request (e.g. LOAD then READ on consecutive cycles returns the loaded value).
- count updates on the same edge as push/pop.
- The first outputs after reset deassertion are the reset values above.

## Structure
- Package item_responder_pkg:
  - op enum: OP_LOAD, OP_ADD, OP_XOR, OP_READ.
  - rsp_t struct: {data, err}.
  - Default DATA_W/DEPTH constants.
- One sub-module, resp_fifo:
  - Parameterized by DEPTH and entry type.
  - Provides push, pop, full, empty and count.
  - Synchronous active-high reset.
- Top level holds the accumulator, op decode and handshake glue.

## Test plan
- Reset check: assert rst 2 cycles with req_valid = 1 → rsp_valid = 0, req_ready = 1, count = 0, no response ever appears for that request.
- Op sequence, rsp_ready = 1: LOAD 0x10, ADD 0x05, XOR 0xFF, READ → responses 0x10/0, 0x15/0, 0xEA/0, 0xEA/0, each 1 cycle after acceptance.
- ADD overflow: LOAD 0xF0, ADD 0x20 → response 0x10 with rsp_err = 1. A following READ returns 0x10/0.
- Backpressure to full (DEPTH = 4): hold rsp_ready = 0 and offer LOAD 1..5 → req_ready drops after the 4th, count = 4, 5th held. Release rsp_ready → drains 1,2,3,4 in order, 5th accepted and returned last.
- Full with simultaneous pop: at count = 4, pulse rsp_ready for one cycle with req_valid = 1 → count 3, req_ready = 1 next cycle, request accepted then, count returns to 4.
- Reset mid-operation: count = 3, acc = 0x55, assert rst → next cycle count = 0, rsp_valid = 0. A subsequent READ returns 0x00/0.
